// File: rtl/mutex_rule_scheduler_if.sv
// Requester-side and observation signals of the mutual-exclusion scheduler.
// The master side drives hold/req/rel; the scheduler drives everything else.
interface mutex_rule_scheduler_if #(
   parameter int N     = 3,
   parameter int CNT_W = 8
);
   logic             io_hold;
   logic [N-1:0]     io_req;
   logic [N-1:0]     io_rel;
   logic [N-1:0]     io_grant;
   logic [2*N-1:0]   io_state;
   logic             io_x;
   logic             io_fire_valid;
   logic [3:0]       io_fire_rule;
   logic [CNT_W-1:0] io_grant_cnt;
   logic             io_err;

   modport master (
      output io_hold, io_req, io_rel,
      input  io_grant, io_state, io_x, io_fire_valid, io_fire_rule,
             io_grant_cnt, io_err
   );

   modport slave (
      input  io_hold, io_req, io_rel,
      output io_grant, io_state, io_x, io_fire_valid, io_fire_rule,
             io_grant_cnt, io_err
   );
endinterface

// File: rtl/mutex_rule_scheduler.sv
// Round-robin scheduler for the N-node Idle/Try/Crit/Exit mutex protocol.
// Fires at most one enabled rule per cycle and owns the shared lock bit.
//
//   state | meaning
//   ------+---------------------------------------------
//   ST_I  | idle, waiting for io_req
//   ST_T  | trying, waiting for the lock to be free
//   ST_C  | critical section, holds the lock (io_grant)
//   ST_E  | exiting, releases the lock on the next firing
module mutex_rule_scheduler #(
   parameter int N     = 3,
   parameter int CNT_W = 8
) (
   input logic                  clock,
   input logic                  reset,
   mutex_rule_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_I = 2'd0,
      ST_T = 2'd1,
      ST_C = 2'd2,
      ST_E = 2'd3
   } node_state_e;

   node_state_e      state_q [4];
   logic             x_q;
   logic [1:0]       ptr_q;
   logic             fire_valid_q;
   logic [3:0]       fire_rule_q;
   logic [CNT_W-1:0] grant_cnt_q;
   logic             err_q;

   logic [3:0]  en;
   logic        win_found;
   logic [1:0]  win_idx;
   logic [2:0]  scan_idx;
   logic [1:0]  ptr_d;
   node_state_e win_state;
   logic [2:0]  ce_cnt;
   logic        violation;

   always_comb begin
      en = '0;
      for (int i = 0; i < N; i++) begin
         case (state_q[i])
            ST_I:    en[i] = bus.io_req[i];
            ST_T:    en[i] = x_q;
            ST_C:    en[i] = bus.io_rel[i];
            default: en[i] = 1'b1;
         endcase
      end
   end

   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      scan_idx  = 3'd0;
      for (int k = 0; k < N; k++) begin
         scan_idx = {1'b0, ptr_q} + 3'(k);
         if (scan_idx >= 3'(N)) scan_idx = scan_idx - 3'(N);
         if (!win_found && en[scan_idx[1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[1:0];
         end
      end
      if ({1'b0, win_idx} + 3'd1 >= 3'(N)) ptr_d = 2'd0;
      else                                 ptr_d = win_idx + 2'd1;
      win_state = state_q[win_idx];
   end

   always_comb begin
      ce_cnt = 3'd0;
      for (int i = 0; i < N; i++) begin
         if (state_q[i] == ST_C || state_q[i] == ST_E) ce_cnt = ce_cnt + 3'd1;
      end
      violation = (ce_cnt > 3'd1) || (x_q && ce_cnt != 3'd0);
   end

   // Rule kind (Try/Crit/Exit/Idle) equals the encoding of the state it fires from.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) state_q[i] <= ST_I;
         x_q          <= 1'b1;
         ptr_q        <= 2'd0;
         fire_valid_q <= 1'b0;
         fire_rule_q  <= 4'd0;
         grant_cnt_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         err_q        <= err_q | violation;
         fire_valid_q <= 1'b0;
         if (win_found && !bus.io_hold) begin
            fire_valid_q <= 1'b1;
            fire_rule_q  <= {win_idx, win_state};
            ptr_q        <= ptr_d;
            case (win_state)
               ST_I: state_q[win_idx] <= ST_T;
               ST_T: begin
                  state_q[win_idx] <= ST_C;
                  x_q              <= 1'b0;
                  grant_cnt_q      <= grant_cnt_q + 1'b1;
               end
               ST_C: state_q[win_idx] <= ST_E;
               default: begin
                  state_q[win_idx] <= ST_I;
                  x_q              <= 1'b1;
               end
            endcase
         end
      end
   end

   always_comb begin
      bus.io_grant = '0;
      bus.io_state = '0;
      for (int i = 0; i < N; i++) begin
         bus.io_grant[i]       = (state_q[i] == ST_C);
         bus.io_state[2*i +: 2] = state_q[i];
      end
   end

   assign bus.io_x          = x_q;
   assign bus.io_fire_valid = fire_valid_q;
   assign bus.io_fire_rule  = fire_rule_q;
   assign bus.io_grant_cnt  = grant_cnt_q;
   assign bus.io_err        = err_q;

endmodule

// File: tb/tb_mutex_rule_scheduler.sv
// Directed bench for mutex_rule_scheduler: stimulus queues expected rule
// indices, a negedge monitor pops and compares on every io_fire_valid.
module tb_mutex_rule_scheduler;
   localparam int N     = 3;
   localparam int CNT_W = 8;

   logic clk;
   logic rst_n;

   mutex_rule_scheduler_if #(.N(N), .CNT_W(CNT_W)) bus ();

   mutex_rule_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int exp_q [$];
   bit sb_en   = 1'b1;
   int crit_seen = 0;

   task automatic chk(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      bus.io_hold = 1'b0;
      bus.io_req  = '0;
      bus.io_rel  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // Scoreboard monitor
   initial begin
      int e;
      forever begin
         @(negedge clk);
         if (bus.io_fire_valid) begin
            if (bus.io_fire_rule[1:0] == 2'd1) crit_seen++;
            if (sb_en) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL fire_unexpected: got rule %0d, expected no firing (t=%0t)",
                           bus.io_fire_rule, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("fire_rule", int'(bus.io_fire_rule), e);
               end
            end
         end
      end
   end

   initial begin
      int exp_g [16];
      int cycles;
      bit multi_hot;
      bit err_seen;

      do_reset();
      chk("rst_state",      int'(bus.io_state), 0);
      chk("rst_x",          int'(bus.io_x), 1);
      chk("rst_fire_valid", int'(bus.io_fire_valid), 0);
      chk("rst_fire_rule",  int'(bus.io_fire_rule), 0);
      chk("rst_grant",      int'(bus.io_grant), 0);
      chk("rst_grant_cnt",  int'(bus.io_grant_cnt), 0);
      chk("rst_err",        int'(bus.io_err), 0);

      // Single node, no contention: Try, Crit, Exit, Idle
      bus.io_req = 3'b001;
      bus.io_rel = 3'b001;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
      step();
      chk("t1_grant_e1", int'(bus.io_grant), 0);
      step();
      chk("t1_grant_e2", int'(bus.io_grant), 1);
      chk("t1_x_e2",     int'(bus.io_x), 0);
      chk("t1_cnt_e2",   int'(bus.io_grant_cnt), 1);
      step();
      chk("t1_grant_e3", int'(bus.io_grant), 0);
      chk("t1_x_e3",     int'(bus.io_x), 0);
      bus.io_req = '0;
      bus.io_rel = '0;
      step();
      chk("t1_x_e4",     int'(bus.io_x), 1);
      chk("t1_state_e4", int'(bus.io_state), 0);
      chk("t1_cnt_e4",   int'(bus.io_grant_cnt), 1);
      step();
      chk("t1_idle_fv",  int'(bus.io_fire_valid), 0);
      chk("t1_sb_drain", exp_q.size(), 0);

      // All three request: grants rotate 0,1,2 then node 0 again
      do_reset();
      bus.io_req = 3'b111;
      bus.io_rel = 3'b111;
      foreach (exp_q[i]) ;
      exp_q = '{0, 4, 8, 1, 2, 3, 5, 0, 6, 7, 9, 10, 11, 1, 2, 3};
      exp_g = '{0, 0, 0, 1, 0, 0, 2, 2, 0, 0, 4, 0, 0, 1, 0, 0};
      for (int s = 0; s < 16; s++) begin
         step();
         chk($sformatf("t2_grant_e%0d", s + 1), int'(bus.io_grant), exp_g[s]);
         if (s == 10) bus.io_req = '0;
      end
      chk("t2_cnt",      int'(bus.io_grant_cnt), 4);
      chk("t2_err",      int'(bus.io_err), 0);
      chk("t2_state",    int'(bus.io_state), 0);
      chk("t2_sb_drain", exp_q.size(), 0);

      // Node 0 holds C with no release; node 1 waits in T forever
      do_reset();
      bus.io_req = 3'b011;
      bus.io_rel = 3'b000;
      exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(1);
      step(); step(); step();
      step();
      chk("t3_stall_fv", int'(bus.io_fire_valid), 0);
      bus.io_req = 3'b111;
      exp_q.push_back(8);
      step();
      step();
      chk("t3_idle_fv1", int'(bus.io_fire_valid), 0);
      step();
      chk("t3_idle_fv2", int'(bus.io_fire_valid), 0);
      chk("t3_state",    int'(bus.io_state), 6'b010110);
      chk("t3_grant",    int'(bus.io_grant), 1);
      chk("t3_rule",     int'(bus.io_fire_rule), 8);

      // Hold for 3 cycles while node 0 Exit is the pending winner
      bus.io_rel  = 3'b001;
      bus.io_hold = 1'b1;
      for (int s = 0; s < 3; s++) begin
         step();
         chk("t4_hold_fv",    int'(bus.io_fire_valid), 0);
         chk("t4_hold_state", int'(bus.io_state), 6'b010110);
      end
      chk("t4_hold_rule", int'(bus.io_fire_rule), 8);
      bus.io_hold = 1'b0;
      exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(5);
      step(); step(); step();
      chk("t4_grant",    int'(bus.io_grant), 2);
      chk("t4_sb_drain", exp_q.size(), 0);

      // Asynchronous reset while node 2 is in C
      do_reset();
      bus.io_req = 3'b100;
      exp_q.push_back(8); exp_q.push_back(9);
      step(); step();
      chk("t5_grant_pre", int'(bus.io_grant), 4);
      chk("t5_cnt_pre",   int'(bus.io_grant_cnt), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_state", int'(bus.io_state), 0);
      chk("t5_x",     int'(bus.io_x), 1);
      chk("t5_grant", int'(bus.io_grant), 0);
      chk("t5_cnt",   int'(bus.io_grant_cnt), 0);
      chk("t5_fv",    int'(bus.io_fire_valid), 0);
      bus.io_req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t5_sb_drain", exp_q.size(), 0);

      // Random req/rel/hold until 300 Crit rules have fired
      do_reset();
      sb_en     = 1'b0;
      crit_seen = 0;
      cycles    = 0;
      multi_hot = 1'b0;
      err_seen  = 1'b0;
      while (crit_seen < 300 && cycles < 20000) begin
         bus.io_req  = 3'($urandom_range(0, 7));
         bus.io_rel  = 3'($urandom_range(0, 7));
         bus.io_hold = ($urandom_range(0, 7) == 0);
         step();
         cycles++;
         if ($countones(bus.io_grant) > 1) multi_hot = 1'b1;
         if (bus.io_err) err_seen = 1'b1;
      end
      chk("t6_crit_reached", crit_seen, 300);
      chk("t6_cnt_wrap",     int'(bus.io_grant_cnt), 44);
      chk("t6_multi_hot",    int'(multi_hot), 0);
      chk("t6_err",          int'(err_seen), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
